// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : state encodings and oversampling constants shared by uart_tx/rx
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  typedef logic [1:0] uart_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with a configurable reset value
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 16x oversampling UART receiver, LSB first, one-cycle done strobe.
//           Optional stop-bit checking via UART_RX_FRAMING_ERR_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int NBITS_DATA   = 8,
  parameter int STOPBITS_TCK = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick_brg,
  input  logic                  i_rx,
  output logic [NBITS_DATA-1:0] o_data,
  output logic                  o_rx_done
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic                  o_frame_err
`endif
);

  localparam int SW = $clog2(STOPBITS_TCK);
  localparam int NW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;

  localparam logic [SW-1:0] MID_CNT       = SW'(MID_TICK);
  localparam logic [SW-1:0] LAST_OS_CNT   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] LAST_STOP_CNT = SW'(STOPBITS_TCK - 1);
  localparam logic [NW-1:0] LAST_BIT      = NW'(NBITS_DATA - 1);

  logic                  rx_s;
  uart_state_t           state_q,  state_d;
  logic [SW-1:0]         s_cnt_q,  s_cnt_d;
  logic [NW-1:0]         n_cnt_q,  n_cnt_d;
  logic [NBITS_DATA-1:0] b_reg_q,  b_reg_d;
  logic [NBITS_DATA-1:0] data_q,   data_d;
  logic                  done_q,   done_d;
`ifdef UART_RX_FRAMING_ERR_EN
  logic                  ferr_q,   ferr_d;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_reg_d = b_reg_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
    ferr_d  = ferr_q;
`endif
    case (state_q)
      // Leaving IDLE is tick-independent so the start edge is caught promptly.
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        if (i_tick_brg) begin
          if (s_cnt_q == MID_CNT) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick_brg) begin
          if (s_cnt_q == LAST_OS_CNT) begin
            s_cnt_d = '0;
            b_reg_d = {rx_s, b_reg_q[NBITS_DATA-1:1]};
            if (n_cnt_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick_brg) begin
          if (s_cnt_q == LAST_STOP_CNT) begin
            state_d = ST_IDLE;
            data_d  = b_reg_q;
            done_d  = 1'b1;
`ifdef UART_RX_FRAMING_ERR_EN
            ferr_d  = ~rx_s;
`endif
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_reg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_reg_q <= b_reg_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef UART_RX_FRAMING_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign o_data    = data_q;
  assign o_rx_done = done_q;
`ifdef UART_RX_FRAMING_ERR_EN
  assign o_frame_err = ferr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed, table-driven self-checking bench for uart_rx
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_tick_brg;
  logic       i_rx;
  logic       i_rx2;
  logic [7:0] o_data;
  logic [7:0] o_data2;
  logic       o_rx_done;
  logic       o_rx_done2;
`ifdef UART_RX_FRAMING_ERR_EN
  logic       o_frame_err;
  logic       o_frame_err2;
`endif

  always #5 clk = ~clk;

  uart_rx #(.NBITS_DATA(8), .STOPBITS_TCK(16)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_tick_brg (i_tick_brg),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done)
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    .o_frame_err(o_frame_err)
`endif
  );

  uart_rx #(.NBITS_DATA(8), .STOPBITS_TCK(32)) dut2 (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_tick_brg (i_tick_brg),
    .i_rx       (i_rx2),
    .o_data     (o_data2),
    .o_rx_done  (o_rx_done2)
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    .o_frame_err(o_frame_err2)
`endif
  );

  // One-cycle tick every third clock, changing away from the rising edge.
  initial begin
    i_tick_brg = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      i_tick_brg = 1'b1;
      @(negedge clk);
      i_tick_brg = 1'b0;
    end
  end

  int tick_cnt = 0;
  always @(posedge clk) if (i_tick_brg) tick_cnt <= tick_cnt + 1;

  logic [7:0] ev_data[$];
  int         ev_tick[$];
  logic [7:0] ev_data2[$];
  int         ev_tick2[$];
  int         data_glitch = 0;
  logic [7:0] prev_data;

  always @(posedge clk) begin
    #1;
    if (o_rx_done === 1'b1) begin
      ev_data.push_back(o_data);
      ev_tick.push_back(tick_cnt);
    end
    if (o_rx_done2 === 1'b1) begin
      ev_data2.push_back(o_data2);
      ev_tick2.push_back(tick_cnt);
    end
    if (i_reset === 1'b1 && o_rx_done !== 1'b1 && o_data !== prev_data) data_glitch++;
    prev_data = o_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (i_tick_brg !== 1'b1);
    #1;
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) i_rx2 = v;
    else       i_rx  = v;
  endtask

  // Sender changes the line just after a tick, like a tick-driven transmitter.
  task automatic send_frame(input bit which, input logic [7:0] d, input logic stop_v,
                            input int stop_ticks, output int t0);
    t0 = tick_cnt;
    set_line(which, 1'b0);
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      repeat (16) wait_tick();
    end
    set_line(which, stop_v);
    repeat (stop_ticks) wait_tick();
    set_line(which, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;        // idle ticks before the frame; 0 = back-to-back
    int         exp_delta;  // ticks from line fall to done edge
  } vec_t;

  vec_t vecs[6];
  int   t0s[6];

  initial begin
    int t0;
    logic [31:0] act;

    // One tick falls inside the synchronizer latency, then 8 + 128 + 16.
    vecs[0] = '{8'h33, 10, 153};
    vecs[1] = '{8'hF2,  0, 153};
    vecs[2] = '{8'h00,  5, 153};
    vecs[3] = '{8'hFF,  0, 153};
    vecs[4] = '{8'h81,  3, 153};
    vecs[5] = '{8'h5A,  0, 153};

    i_reset = 1'b0;
    i_rx    = 1'b1;
    i_rx2   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_o_data", {24'h0, o_data}, 32'h0);
    check("reset_o_rx_done", {31'h0, o_rx_done}, 32'h0);
`ifdef UART_RX_FRAMING_ERR_EN
    check("reset_o_frame_err", {31'h0, o_frame_err}, 32'h0);
`endif
    @(negedge clk);
    i_reset = 1'b1;
    repeat (4) wait_tick();

    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].gap) wait_tick();
      send_frame(1'b0, vecs[i].data, 1'b1, 16, t0s[i]);
    end
    repeat (20) wait_tick();
    check("table_pulse_count", ev_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      act = (i < ev_data.size()) ? {24'h0, ev_data[i]} : 32'hDEAD;
      check($sformatf("table_data[%0d]", i), act, {24'h0, vecs[i].data});
      act = (i < ev_tick.size()) ? ev_tick[i] - t0s[i] : 32'hDEAD;
      check($sformatf("table_latency[%0d]", i), act, vecs[i].exp_delta);
    end

    // False start: 4 ticks low, then back to idle.
    ev_data.delete(); ev_tick.delete();
    set_line(1'b0, 1'b0);
    repeat (4) wait_tick();
    set_line(1'b0, 1'b1);
    repeat (30) wait_tick();
    check("false_start_no_pulse", ev_data.size(), 0);
    check("false_start_data_held", {24'h0, o_data}, 32'h5A);

    // Reset after the third data bit of a 0x81 frame.
    set_line(1'b0, 1'b0);
    repeat (16) wait_tick();
    for (int i = 0; i < 3; i++) begin
      set_line(1'b0, (i == 0) ? 1'b1 : 1'b0);
      repeat (16) wait_tick();
    end
    @(negedge clk);
    i_reset = 1'b0;
    i_rx    = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_o_data", {24'h0, o_data}, 32'h0);
    check("midreset_o_rx_done", {31'h0, o_rx_done}, 32'h0);
`ifdef UART_RX_FRAMING_ERR_EN
    check("midreset_o_frame_err", {31'h0, o_frame_err}, 32'h0);
`endif
    @(negedge clk);
    i_reset = 1'b1;
    repeat (20) wait_tick();
    check("midreset_no_pulse", ev_data.size(), 0);
    send_frame(1'b0, 8'h81, 1'b1, 16, t0);
    repeat (20) wait_tick();
    check("after_reset_pulse_count", ev_data.size(), 1);
    act = (ev_data.size() > 0) ? {24'h0, ev_data[0]} : 32'hDEAD;
    check("after_reset_data", act, 32'h81);
    act = (ev_tick.size() > 0) ? ev_tick[0] - t0 : 32'hDEAD;
    check("after_reset_latency", act, 153);

`ifdef UART_RX_FRAMING_ERR_EN
    ev_data.delete(); ev_tick.delete();
    send_frame(1'b0, 8'hA5, 1'b0, 16, t0);
    repeat (20) wait_tick();
    check("ferr_pulse_count", ev_data.size(), 1);
    check("ferr_data", {24'h0, o_data}, 32'hA5);
    check("ferr_set", {31'h0, o_frame_err}, 32'h1);
    send_frame(1'b0, 8'h5A, 1'b1, 16, t0);
    repeat (20) wait_tick();
    check("ferr_clear_pulse_count", ev_data.size(), 2);
    check("ferr_clear_data", {24'h0, o_data}, 32'h5A);
    check("ferr_cleared", {31'h0, o_frame_err}, 32'h0);
`endif

    // Two stop bits: 1 + 8 + 128 + 32 ticks.
    send_frame(1'b1, 8'h0F, 1'b1, 32, t0);
    repeat (20) wait_tick();
    check("stop2_pulse_count", ev_data2.size(), 1);
    act = (ev_data2.size() > 0) ? {24'h0, ev_data2[0]} : 32'hDEAD;
    check("stop2_data", act, 32'h0F);
    act = (ev_tick2.size() > 0) ? ev_tick2[0] - t0 : 32'hDEAD;
    check("stop2_latency", act, 169);

    check("data_only_on_done", data_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver, the counterpart of `uart_tx` on the same serial line. It oversamples the line at 16 baud-generator ticks per bit, detects a start bit, and samples each data bit at its midpoint, LSB first. It checks the stop bit, then presents the received word with a one-cycle done strobe. It takes the same `i_tick_brg` from the baud-rate generator as `uart_tx` and feeds the UART-to-ALU interface logic.

## Interface
- `NBITS_DATA`, default 8: data bits per frame.
- `STOPBITS_TCK`, default 16: stop-bit length in ticks. 16 means 1 stop bit, 24 means 1.5, 32 means 2.

- `i_clk` in 1: system clock. Single clock domain.
- `i_reset` in 1: synchronous, active-low reset. Sampled on the `i_clk` rising edge.
- `i_tick_brg` in 1: oversampling tick at 16× baud. Each tick is one `i_clk` cycle wide.
- `i_rx` in 1: serial line, asynchronous. Idle level is 1.
- `o_data` out NBITS_DATA: last received word. Holds its value until the next valid frame.
- `o_rx_done` out 1: one-cycle pulse when a frame completes.
- `o_frame_err` out 1: present only with `UART_RX_FRAMING_ERR_EN` (see Configuration).

## Operation
- **Input synchronizer:** `i_rx` passes through a 2-FF synchronizer. Reset preloads both flops to 1. All logic below uses the synchronized value `rx_s`.
- **Counters:** tick counter `s_cnt` is wide enough for `STOPBITS_TCK-1`. Bit counter `n_cnt` is `$clog2(NBITS_DATA)` bits. There is an `NBITS_DATA`-bit shift register `b_reg`.
- **Tick gating:** counters advance only in cycles where `i_tick_brg`=1.
- **IDLE:**
  - `rx_s`=0 moves to START and clears `s_cnt`.
  - Ticks are not required to leave IDLE.
- **START:** on a tick with `s_cnt`==7 (mid start bit):
  - `rx_s`=0: clear `s_cnt` and `n_cnt`, go to DATA.
  - `rx_s`=1: false start, return to IDLE with no output change.
- **DATA:** on a tick with `s_cnt`==15:
  - Clear `s_cnt`.
  - Shift right: `b_reg` <= {`rx_s`, `b_reg`[NBITS_DATA-1:1]}.
  - If `n_cnt`==NBITS_DATA-1, go to STOP; otherwise increment `n_cnt`.
- **STOP:** on a tick with `s_cnt`==STOPBITS_TCK-1, sample `rx_s`, go to IDLE, and:
  - Load `o_data` <= `b_reg`.
  - Pulse `o_rx_done`.
  - With the feature compiled in and a stop sample of 0: `o_data` still loads, `o_rx_done` still pulses, and `o_frame_err` is set.
- **Back-to-back frames:** a start bit that begins immediately after the stop bit is accepted from IDLE.
- **Reset mid-frame:** the frame is aborted. State, counters and `b_reg` clear, and no `o_rx_done` is produced.
- **Reset values:**
  - state IDLE
  - `s_cnt`=0, `n_cnt`=0, `b_reg`=0
  - `o_data`=0, `o_rx_done`=0, `o_frame_err`=0

## Timing
- **Synchronizer latency:** 2 `i_clk` cycles from an `i_rx` edge to `rx_s`.
- **Bit sampling:** the start bit is validated on its 8th tick. Each data bit is sampled 16 ticks after the previous sample point.
- **Done strobe:** `o_rx_done` is registered. It rises on the `i_clk` edge that consumes the final stop tick and stays high for exactly one cycle.
- **Frame length:** with defaults, `o_rx_done` rises 8 + 8·16 + 16 = 152 ticks after IDLE sees `rx_s`=0.
- **`o_data`** changes only on the `o_rx_done` edge.
- **Reset priority:** `i_reset`=0 overrides any simultaneous tick or line event.

## Configuration
- **`UART_RX_FRAMING_ERR_EN` defined:**
  - Port `o_frame_err` exists.
  - It is set on the `o_rx_done` edge when the stop sample is 0.
  - It is cleared on the next `o_rx_done` edge with a valid stop bit, or by reset.
- **Not defined:** the port and its register are absent, and the stop-bit value is ignored.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding constants: `ST_IDLE`=2'b00, `ST_START`=2'b01, `ST_DATA`=2'b10, `ST_STOP`=2'b11.
  - `OVERSAMPLE`=16 and `MID_TICK`=7.
  - `uart_tx` uses the same package.
- **Sub-module `sync_2ff`:** parameterized reset value, instantiated once for `i_rx`.
- **FSM style:** registered state plus next-state logic.

## Test plan
- **Basic frame:** send 0x33 at 8N1 with the tick every 3 clk. Expect `o_data`=8'h33, `o_rx_done` high for 1 cycle, and no further pulses.
- **Back-to-back:** send 0x33 then 0xF2 with no idle gap. Expect two pulses, `o_data`=8'h33 then 8'hF2, and each pulse 152 ticks after its start edge.
- **False start:** drive `i_rx` low for 4 ticks, then high. Expect return to IDLE, no `o_rx_done`, and `o_data` unchanged.
- **Framing error** (macro defined): send 0xA5 with stop bit 0. Expect `o_data`=8'hA5, one pulse, `o_frame_err`=1. A following valid frame 0x5A clears `o_frame_err` to 0.
- **Reset mid-frame:** assert `i_reset`=0 for 1 cycle after the 3rd data bit. Expect all outputs 0 and no pulse. The next 0x81 frame is received correctly.
- **Two stop bits:** set `STOPBITS_TCK`=32 and send 0x0F. Expect the pulse 168 ticks after the start edge with `o_data`=8'h0F.
